// File: rtl/wave_pattern_gen_pkg.sv
// Shared types for the programmable waveform generator: FSM states, the
// config bundle and the "zero means one" duration helper.
package wave_pattern_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {WG_IDLE, WG_PHASE, WG_HIGH, WG_LOW} wg_state_t;

  typedef struct packed {
    logic [CNT_W_DEF-1:0] phase;
    logic [CNT_W_DEF-1:0] high;
    logic [CNT_W_DEF-1:0] low;
    logic [CNT_W_DEF-1:0] count;
  } wg_cfg_t;

  function automatic logic [CNT_W_DEF-1:0] at_least_one(input logic [CNT_W_DEF-1:0] v);
    return (v == '0) ? CNT_W_DEF'(1) : v;
  endfunction

endpackage

// File: rtl/wave_pattern_gen_down_counter.sv
// Loadable down-counter timing each FSM state; 'last' marks the final cycle
// of the current state (a load of 0 or 1 is a single-cycle state).
module wg_down_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             last
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign last = (cnt <= CNT_W'(1));

endmodule

// File: rtl/wave_pattern_gen.sv
// Programmable divided waveform with phase offset, edge strobes and a
// period counter; config arrives over a valid/ready handshake in IDLE.
module wave_pattern_gen
  import wave_pattern_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_phase,
  input  logic [CNT_W-1:0] cfg_high,
  input  logic [CNT_W-1:0] cfg_low,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic             start,
  input  logic             stop,
  output logic             wave_out,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] period_cnt
);

  wg_state_t        state, state_n;
  wg_cfg_t          shadow, in_cfg, eff;
  logic             cap;
  logic             last;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic [CNT_W-1:0] pc_inc;
  logic             wave_d, rise_d, fall_d, done_d;

  assign in_cfg = '{phase: cfg_phase, high: cfg_high, low: cfg_low, count: cfg_count};
  assign cap    = cfg_valid && (state == WG_IDLE);
  // A capture in the same cycle as start must steer the run being launched.
  assign eff    = cap ? in_cfg : shadow;
  assign pc_inc = (period_cnt == '1) ? period_cnt : period_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '{phase: '0, high: CNT_W_DEF'(1), low: CNT_W_DEF'(1), count: '0};
    end else if (cap) begin
      shadow <= in_cfg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WG_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      WG_IDLE: begin
        if (start && !stop) begin
          state_n = (eff.phase != '0) ? WG_PHASE : WG_HIGH;
        end
      end
      WG_PHASE: begin
        if (stop)      state_n = WG_IDLE;
        else if (last) state_n = WG_HIGH;
      end
      WG_HIGH: begin
        if (stop)      state_n = WG_IDLE;
        else if (last) state_n = WG_LOW;
      end
      WG_LOW: begin
        if (stop) begin
          state_n = WG_IDLE;
        end else if (last) begin
          state_n = ((eff.count != '0) && (pc_inc == eff.count)) ? WG_IDLE : WG_HIGH;
        end
      end
      default: state_n = WG_IDLE;
    endcase
  end

  always_comb begin
    cnt_load = (state_n != state) && (state_n != WG_IDLE);
    cnt_val  = '0;
    unique case (state_n)
      WG_PHASE: cnt_val = eff.phase;
      WG_HIGH:  cnt_val = at_least_one(eff.high);
      WG_LOW:   cnt_val = at_least_one(eff.low);
      default:  cnt_val = '0;
    endcase
  end

  wg_down_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (1'b1),
    .last     (last)
  );

  // Outputs are registered alongside the state they describe.
  always_comb begin
    wave_d = (state_n == WG_HIGH);
    rise_d = (state_n == WG_HIGH) && (state != WG_HIGH);
    fall_d = (state_n == WG_LOW) && (state == WG_HIGH);
    done_d = (state == WG_LOW) && (state_n == WG_IDLE) && !stop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wave_out   <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      done       <= 1'b0;
    end else begin
      wave_out   <= wave_d;
      rise_pulse <= rise_d;
      fall_pulse <= fall_d;
      done       <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      period_cnt <= '0;
    end else if ((state == WG_IDLE) && (state_n != WG_IDLE)) begin
      period_cnt <= '0;
    end else if ((state == WG_LOW) && last && !stop) begin
      period_cnt <= pc_inc;
    end
  end

  assign cfg_ready = (state == WG_IDLE);
  assign busy      = (state != WG_IDLE);

endmodule

// File: tb/tb_wave_pattern_gen.sv
// Self-checking bench: directed scenarios plus random runs compared each cycle
// against a closed-form timeline model of the waveform.
module tb_wave_pattern_gen;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst, cfg_valid, cfg_ready, start, stop;
  logic [W-1:0] cfg_phase, cfg_high, cfg_low, cfg_count;
  logic         wave_out, rise_pulse, fall_pulse, busy, done;
  logic [W-1:0] period_cnt;

  int checks   = 0;
  int failures = 0;

  // Config parked on the bus during a run when hold_b is set.
  bit hold_b = 0;
  int b_ph, b_hi, b_lo, b_cnt;

  always #5 clk = ~clk;

  wave_pattern_gen dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_phase  (cfg_phase),
    .cfg_high   (cfg_high),
    .cfg_low    (cfg_low),
    .cfg_count  (cfg_count),
    .start      (start),
    .stop       (stop),
    .wave_out   (wave_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .busy       (busy),
    .done       (done),
    .period_cnt (period_cnt)
  );

  typedef struct {
    bit wave, rise, fall, busy, done;
    int pc;
  } exp_t;

  // Expected outputs t cycles after the start edge (t=1 is the first cycle).
  function automatic exp_t model(int ph, int h, int l, int cnt, int stop_t, int t);
    exp_t e;
    int heff, leff, p, done_t, tt, u, w;
    bit ab;
    heff   = (h == 0) ? 1 : h;
    leff   = (l == 0) ? 1 : l;
    p      = heff + leff;
    done_t = (cnt != 0) ? ph + cnt * p + 1 : 32'h7fff_ffff;
    tt     = t;
    ab     = 0;
    e      = '{default: 0};
    if (stop_t > 0 && t > stop_t && stop_t < done_t) begin
      ab = 1;
      tt = stop_t;
    end
    if (tt >= done_t) begin
      e.pc   = cnt;
      e.done = (tt == done_t);
      return e;
    end
    e.busy = !ab;
    if (tt > ph) begin
      u    = tt - ph - 1;
      w    = u % p;
      e.pc = u / p;
      if (!ab) begin
        e.wave = (w < heff);
        e.rise = (w == 0);
        e.fall = (w == heff);
      end
    end
    return e;
  endfunction

  task automatic check(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  task automatic check_all(input exp_t e);
    check("wave_out",   int'(wave_out),   int'(e.wave));
    check("rise_pulse", int'(rise_pulse), int'(e.rise));
    check("fall_pulse", int'(fall_pulse), int'(e.fall));
    check("busy",       int'(busy),       int'(e.busy));
    check("cfg_ready",  int'(cfg_ready),  int'(!e.busy));
    check("done",       int'(done),       int'(e.done));
    check("period_cnt", int'(period_cnt), e.pc);
  endtask

  // Launch one run and compare every cycle for ncyc cycles. give_cfg offers
  // the config in the start cycle; otherwise the previously captured one runs.
  task automatic run(input int ph, input int h, input int l, input int cnt,
                     input bit give_cfg, input int stop_t, input int ncyc);
    @(negedge clk);
    cfg_phase = W'(ph); cfg_high = W'(h); cfg_low = W'(l); cfg_count = W'(cnt);
    cfg_valid = give_cfg;
    start     = 1'b1;
    stop      = 1'b0;
    @(posedge clk);
    #1;
    start     = 1'b0;
    cfg_valid = 1'b0;
    if (hold_b) begin
      cfg_phase = W'(b_ph); cfg_high = W'(b_hi); cfg_low = W'(b_lo); cfg_count = W'(b_cnt);
      cfg_valid = 1'b1;
    end
    for (int t = 1; t <= ncyc; t++) begin
      @(negedge clk);
      check_all(model(ph, h, l, cnt, stop_t, t));
      stop = (t == stop_t);
    end
    stop = 1'b0;
  endtask

  function automatic int run_len(int ph, int h, int l, int cnt);
    return ph + cnt * (((h == 0) ? 1 : h) + ((l == 0) ? 1 : l)) + 1;
  endfunction

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; start = 1'b0; stop = 1'b0;
    cfg_phase = '0; cfg_high = '0; cfg_low = '0; cfg_count = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all('{wave: 0, rise: 0, fall: 0, busy: 0, done: 0, pc: 0});
    rst = 1'b0;

    // 5/10/5 for three periods
    run(5, 10, 5, 3, 1, 0, run_len(5, 10, 5, 3) + 3);

    // free-running 1/1 toggle, aborted during a HIGH cycle
    run(0, 1, 1, 0, 1, 7, 12);

    // zero high/low behave as one cycle each
    run(0, 0, 0, 2, 1, 0, run_len(0, 0, 0, 2) + 2);

    // config held valid through a run is taken in the first idle cycle
    hold_b = 1; b_ph = 2; b_hi = 3; b_lo = 2; b_cnt = 2;
    run(1, 2, 2, 1, 1, 0, run_len(1, 2, 2, 1) + 2);
    hold_b = 0;
    @(negedge clk);
    cfg_valid = 1'b0;
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check("start_stop_busy", int'(busy), 0);
    check("start_stop_wave", int'(wave_out), 0);
    run(2, 3, 2, 2, 0, 0, run_len(2, 3, 2, 2) + 2);

    // reset in the middle of a HIGH phase
    fork
      run(5, 10, 5, 0, 1, 0, 8);
    join
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all('{wave: 0, rise: 0, fall: 0, busy: 0, done: 0, pc: 0});
    // shadow config back to 0/1/1/free-run after reset
    run(0, 1, 1, 0, 0, 5, 8);

    // single period with a fresh config bypassing the shadow
    run(3, 4, 2, 1, 1, 0, run_len(3, 4, 2, 1) + 2);

    // random configurations, some aborted
    for (int i = 0; i < 8; i++) begin
      int ph, h, l, cnt, len, st;
      ph  = $urandom_range(0, 4);
      h   = $urandom_range(0, 5);
      l   = $urandom_range(0, 5);
      cnt = $urandom_range(0, 3);
      len = (cnt == 0) ? 30 : run_len(ph, h, l, cnt);
      st  = ((cnt == 0) || ($urandom_range(0, 1) == 1)) ? $urandom_range(1, len - 1) : 0;
      run(ph, h, l, cnt, 1, st, ((st != 0) ? st : len) + 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
